// File: rtl/memoria_dados_banco.sv
// Single-port data memory with request handshake, byte masks and a sequential clear engine.
// Optional per-word even parity when MEM_DADOS_PARIDADE_EN is defined.
module memoria_dados_banco #(
    parameter int BITS_PALAVRA  = 16,
    parameter int BITS_ENDERECO = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      req_valido,
    output logic                      req_pronto,
    input  logic                      hab_escrita,
    input  logic [BITS_PALAVRA/8-1:0] mascara,
    input  logic [BITS_ENDERECO-1:0]  endereco,
    input  logic [BITS_PALAVRA-1:0]   entrada,
    output logic [BITS_PALAVRA-1:0]   saida,
    output logic                      saida_valida,
    input  logic                      limpar,
`ifdef MEM_DADOS_PARIDADE_EN
    input  logic                      inverte_paridade,
    output logic                      erro_paridade,
`endif
    output logic                      ocupado
);

    localparam int FAIXAS = BITS_PALAVRA / 8;
    localparam int PROF   = 2 ** BITS_ENDERECO;

    localparam logic [0:0] LIMPANDO = 1'b0;
    localparam logic [0:0] OCIOSO   = 1'b1;

    localparam logic [BITS_ENDERECO-1:0] ULTIMO = '1;

    logic [0:0]               estado;
    logic [BITS_ENDERECO-1:0] contador;
    logic [BITS_PALAVRA-1:0]  mem [PROF];

    logic                     aceito;
    logic                     aceita_escrita;
    logic                     aceita_leitura;
    logic [BITS_PALAVRA-1:0]  atual;
    logic [BITS_PALAVRA-1:0]  mesclada;

    assign req_pronto = (estado == OCIOSO);
    assign ocupado    = (estado == LIMPANDO);

    assign aceito         = req_valido && req_pronto && reset;
    assign aceita_escrita = aceito && hab_escrita && (|mascara);
    assign aceita_leitura = aceito && !hab_escrita;

    assign atual = mem[endereco];

    // Unmasked lanes keep their stored bytes so parity covers the whole word.
    always_comb begin
        mesclada = atual;
        for (int i = 0; i < FAIXAS; i++) begin
            if (mascara[i]) begin
                mesclada[8*i +: 8] = entrada[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            if (estado == LIMPANDO) begin
                mem[contador] <= '0;
            end else if (aceita_escrita) begin
                mem[endereco] <= mesclada;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            estado       <= LIMPANDO;
            contador     <= '0;
            saida        <= '0;
            saida_valida <= 1'b0;
        end else begin
            saida_valida <= aceita_leitura;
            if (aceita_leitura) begin
                saida <= atual;
            end
            case (estado)
                LIMPANDO: begin
                    contador <= contador + 1'b1;
                    if (contador == ULTIMO) begin
                        estado <= OCIOSO;
                    end
                end
                OCIOSO: begin
                    if (limpar) begin
                        estado   <= LIMPANDO;
                        contador <= '0;
                    end
                end
                default: begin
                    estado   <= LIMPANDO;
                    contador <= '0;
                end
            endcase
        end
    end

`ifdef MEM_DADOS_PARIDADE_EN
    logic par [PROF];

    always_ff @(posedge clock) begin
        if (reset) begin
            if (estado == LIMPANDO) begin
                par[contador] <= 1'b0;
            end else if (aceita_escrita) begin
                par[endereco] <= (^mesclada) ^ inverte_paridade;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            erro_paridade <= 1'b0;
        end else begin
            erro_paridade <= aceita_leitura && ((^atual) != par[endereco]);
        end
    end
`endif

endmodule
